// File: rtl/mips_pc_sequencer_if.sv
// Control/status bundle between the MIPS decode stage and the PC sequencer.
// The decode side uses "master"; the sequencer uses "slave".
interface mips_pc_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             zero;
    logic             beq;
    logic             bne;
    logic             jump;
    logic             jal;
    logic             jr;
    logic [15:0]      imm16;
    logic [25:0]      target26;
    logic [31:0]      rs_val;
    logic             stall;
    logic [31:0]      pc;
    logic [31:0]      pc_plus4;
    logic [31:0]      link_addr;
    logic             link_we;
    logic             fetch_valid;
    logic             trap;
    logic [31:0]      epc;
    logic [CNT_W-1:0] br_taken_cnt;

    modport master (
        output zero, beq, bne, jump, jal, jr, imm16, target26, rs_val, stall,
        input  pc, pc_plus4, link_addr, link_we, fetch_valid, trap, epc, br_taken_cnt
    );

    modport slave (
        input  zero, beq, bne, jump, jal, jr, imm16, target26, rs_val, stall,
        output pc, pc_plus4, link_addr, link_we, fetch_valid, trap, epc, br_taken_cnt
    );
endinterface

// File: rtl/mips_pc_sequencer.sv
// Program counter and next-PC selection for a single-cycle MIPS core, with a
// start-up hold state, a misaligned-JR trap that captures EPC, and a taken-branch counter.
module mips_pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080,
    parameter int          CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mips_pc_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } state_t;

    state_t           state_reg;
    logic [31:0]      pc_reg;
    logic [31:0]      epc_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             trap_reg;
    logic             fetch_valid_reg;

    logic [31:0] pc_plus4;
    logic [31:0] br_offset;
    logic [31:0] jump_target;
    logic        jr_misaligned;
    logic        br_taken;

    assign pc_plus4      = pc_reg + 32'd4;
    assign br_offset     = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
    assign jump_target   = {pc_plus4[31:28], bus.target26, 2'b00};
    assign jr_misaligned = bus.jr && (bus.rs_val[1:0] != 2'b00);
    // beq and bne together mean "taken if either condition holds".
    assign br_taken      = (bus.beq && bus.zero) || (bus.bne && !bus.zero);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_HOLD;
            pc_reg          <= RESET_VECTOR;
            epc_reg         <= 32'h0;
            cnt_reg         <= '0;
            trap_reg        <= 1'b0;
            fetch_valid_reg <= 1'b0;
        end else begin
            // The trap pulse always drops after one cycle, stalled or not.
            trap_reg <= 1'b0;
            if (!bus.stall) begin
                case (state_reg)
                    ST_HOLD, ST_TRAP: begin
                        state_reg       <= ST_RUN;
                        fetch_valid_reg <= 1'b1;
                    end
                    ST_RUN: begin
                        if (jr_misaligned) begin
                            pc_reg          <= EXC_VECTOR;
                            epc_reg         <= pc_reg;
                            state_reg       <= ST_TRAP;
                            trap_reg        <= 1'b1;
                            fetch_valid_reg <= 1'b0;
                        end else if (bus.jr) begin
                            pc_reg <= bus.rs_val;
                        end else if (bus.jump) begin
                            pc_reg <= jump_target;
                        end else if (br_taken) begin
                            pc_reg <= pc_plus4 + br_offset;
                            if (cnt_reg != {CNT_W{1'b1}})
                                cnt_reg <= cnt_reg + 1'b1;
                        end else begin
                            pc_reg <= pc_plus4;
                        end
                    end
                    default: begin
                        state_reg       <= ST_HOLD;
                        fetch_valid_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.pc           = pc_reg;
    assign bus.pc_plus4     = pc_plus4;
    assign bus.link_addr    = pc_plus4;
    assign bus.link_we      = bus.jump && bus.jal && (state_reg == ST_RUN) && !bus.stall;
    assign bus.fetch_valid  = fetch_valid_reg;
    assign bus.trap         = trap_reg;
    assign bus.epc          = epc_reg;
    assign bus.br_taken_cnt = cnt_reg;
endmodule

// File: tb/tb_mips_pc_sequencer.sv
// Directed bench for mips_pc_sequencer: expected PCs are queued as each step is
// driven and popped when the registered PC is sampled after the edge.
module tb_mips_pc_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mips_pc_sequencer_if #(.CNT_W(16)) bus ();

    mips_pc_sequencer #(
        .RESET_VECTOR(32'h0000_0000),
        .EXC_VECTOR  (32'h0000_0080),
        .CNT_W       (16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.zero = 1'b0; bus.beq = 1'b0; bus.bne = 1'b0;
        bus.jump = 1'b0; bus.jal = 1'b0; bus.jr = 1'b0;
        bus.imm16 = 16'h0; bus.target26 = 26'h0; bus.rs_val = 32'h0;
        bus.stall = 1'b0;
    endtask

    // Push the expected next PC, clock once, then pop and compare.
    task automatic step(input string tag, input logic [31:0] exp_pc);
        logic [31:0] e;
        exp_q.push_back(exp_pc);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        $display("step %s pc=%h exp=%h fv=%0b trap=%0b cnt=%0d",
                 tag, bus.pc, e, bus.fetch_valid, bus.trap, bus.br_taken_cnt);
        check(tag, bus.pc, e);
    endtask

    initial begin
        idle();
        #1;
        check("rst_pc", bus.pc, 32'h0);
        check("rst_fv", bus.fetch_valid, 1'b0);
        check("rst_trap", bus.trap, 1'b0);
        check("rst_epc", bus.epc, 32'h0);
        check("rst_cnt", bus.br_taken_cnt, 16'h0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("hold_pc", bus.pc, 32'h0);
        check("hold_fv", bus.fetch_valid, 1'b0);

        step("hold_exit", 32'h0);
        check("run_fv", bus.fetch_valid, 1'b1);
        step("seq4", 32'h4);
        step("seq8", 32'h8);
        step("seqC", 32'hC);
        step("seq10", 32'h10);

        bus.beq = 1'b1; bus.zero = 1'b1; bus.imm16 = 16'hFFFC;
        step("beq_back", 32'h4);
        idle();
        check("beq_cnt", bus.br_taken_cnt, 16'd1);
        step("seq8b", 32'h8);
        step("seqCb", 32'hC);
        step("seq10b", 32'h10);

        bus.bne = 1'b1; bus.zero = 1'b1; bus.imm16 = 16'h0010;
        step("bne_not", 32'h14);
        idle();
        check("bne_cnt", bus.br_taken_cnt, 16'd1);

        bus.beq = 1'b1; bus.bne = 1'b1; bus.zero = 1'b0; bus.imm16 = 16'h0002;
        step("beq_bne", 32'h20);
        idle();
        check("both_cnt", bus.br_taken_cnt, 16'd2);

        bus.jr = 1'b1; bus.rs_val = 32'h4000_0020;
        step("jr_hi", 32'h4000_0020);
        idle();
        bus.jump = 1'b1; bus.jal = 1'b1; bus.target26 = 26'h000_0100;
        #1;
        check("jal_we", bus.link_we, 1'b1);
        check("jal_link", bus.link_addr, 32'h4000_0024);
        step("jal", 32'h4000_0400);
        idle();
        #1;
        check("idle_we", bus.link_we, 1'b0);

        bus.jr = 1'b1; bus.rs_val = 32'h30;
        step("jr30", 32'h30);
        bus.rs_val = 32'h102;
        step("jr_mis", 32'h80);
        idle();
        check("trap_epc", bus.epc, 32'h30);
        check("trap_on", bus.trap, 1'b1);
        check("trap_fv", bus.fetch_valid, 1'b0);
        bus.jump = 1'b1; bus.jal = 1'b1; bus.target26 = 26'h3FF_FFFF;
        #1;
        check("trap_we", bus.link_we, 1'b0);
        step("trap_exit", 32'h80);
        idle();
        check("trap_off", bus.trap, 1'b0);
        check("resume_fv", bus.fetch_valid, 1'b1);
        step("seq84", 32'h84);

        bus.jr = 1'b1; bus.rs_val = 32'h200; bus.jump = 1'b1;
        bus.beq = 1'b1; bus.zero = 1'b1; bus.imm16 = 16'h0040;
        step("prio_jr", 32'h200);
        check("prio_cnt", bus.br_taken_cnt, 16'd2);

        idle();
        bus.stall = 1'b1; bus.beq = 1'b1; bus.zero = 1'b1;
        bus.jump = 1'b1; bus.jal = 1'b1; bus.target26 = 26'h000_0001;
        #1;
        check("stall_we", bus.link_we, 1'b0);
        step("stall1", 32'h200);
        step("stall2", 32'h200);
        step("stall3", 32'h200);
        check("stall_cnt", bus.br_taken_cnt, 16'd2);
        idle();
        bus.stall = 1'b1; bus.jr = 1'b1; bus.rs_val = 32'h3;
        step("stall_jr", 32'h200);
        check("stall_trap", bus.trap, 1'b0);
        check("stall_epc", bus.epc, 32'h30);

        idle();
        bus.jr = 1'b1; bus.rs_val = 32'hFFFF_FFFC;
        step("jr_top", 32'hFFFF_FFFC);
        idle();
        step("wrap", 32'h0);

        bus.beq = 1'b1; bus.zero = 1'b1; bus.imm16 = 16'h0;
        repeat (65537) @(posedge clk);
        #1;
        check("sat_cnt", bus.br_taken_cnt, 16'hFFFF);
        step("sat_hold", bus.pc + 32'h4);
        check("sat_stay", bus.br_taken_cnt, 16'hFFFF);

        idle();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_pc", bus.pc, 32'h0);
        check("arst_cnt", bus.br_taken_cnt, 16'h0);
        check("arst_fv", bus.fetch_valid, 1'b0);
        check("arst_epc", bus.epc, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
